// File: rtl/tile_sched.sv
// Tile scheduler: walks the n/k/d tile loop nest of one layer and streams one descriptor per tile.
// Latency: first descriptor valid the cycle after an accepted start, then one per cycle under ready.
// Backpressure: descriptor fields are held stable while desc_valid && !desc_ready; no internal buffering.
module tile_sched #(
  parameter int PIX_W = 16,
  parameter int CH_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       layer_type,
  input  logic [CH_W-1:0]  in_C,
  input  logic [CH_W-1:0]  out_C,
  input  logic [CH_W-1:0]  tile_D,
  input  logic [CH_W-1:0]  tile_K,
  input  logic [31:0]      tile_n,
  input  logic [PIX_W-1:0] num_pix,
  output logic             desc_valid,
  input  logic             desc_ready,
  output logic [CH_W-1:0]  d_base,
  output logic [CH_W-1:0]  d_len,
  output logic [CH_W-1:0]  k_base,
  output logic [CH_W-1:0]  k_len,
  output logic [PIX_W-1:0] n_base,
  output logic [PIX_W-1:0] n_len,
  output logic             first_d,
  output logic             last_d,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
  localparam logic [1:0] LT_DW = 2'd1;

  state_t state_q, state_d;

  // Layer configuration latched at start; inputs are ignored afterwards.
  logic             dw_q;
  logic [CH_W-1:0]  in_c_q, out_c_q, tile_d_q, tile_k_q;
  logic [PIX_W-1:0] n_step_q, num_pix_q;

  logic [CH_W-1:0]  d_base_q, d_base_d, k_base_q, k_base_d;
  logic [PIX_W-1:0] n_base_q, n_base_d;
  logic             err_q, err_d;

  logic             accept, cfg_bad;
  logic [PIX_W-1:0] n_step_new;
  logic [CH_W-1:0]  d_rem, k_rem, d_len_w, k_len_w;
  logic [PIX_W-1:0] n_rem, n_len_w;
  logic [CH_W:0]    d_nxt, k_nxt;
  logic [PIX_W:0]   n_nxt;
  logic             d_wrap, k_wrap, n_wrap;
  logic             issuing;

  assign accept  = (state_q == S_IDLE) && start;
  assign cfg_bad = (tile_n == 32'd0) || (tile_D == '0) || (tile_K == '0) ||
                   (in_C == '0) || (out_C == '0) || (num_pix == '0);
  // Compare at full 32 bits so a tile_n above 2^PIX_W is not mistaken for a small one.
  assign n_step_new = (tile_n < {{(32-PIX_W){1'b0}}, num_pix}) ? tile_n[PIX_W-1:0] : num_pix;

  // Ragged edge lengths: remaining extent clipped to the tile size.
  assign d_rem   = in_c_q - d_base_q;
  assign k_rem   = out_c_q - k_base_q;
  assign n_rem   = num_pix_q - n_base_q;
  assign d_len_w = (tile_d_q < d_rem) ? tile_d_q : d_rem;
  assign k_len_w = (tile_k_q < k_rem) ? tile_k_q : k_rem;
  assign n_len_w = (n_step_q < n_rem) ? n_step_q : n_rem;

  // One extra bit on the advance so base+step can never wrap past the limit.
  assign d_nxt  = {1'b0, d_base_q} + {1'b0, tile_d_q};
  assign k_nxt  = {1'b0, k_base_q} + {1'b0, tile_k_q};
  assign n_nxt  = {1'b0, n_base_q} + {1'b0, n_step_q};
  assign d_wrap = dw_q || (d_nxt >= {1'b0, in_c_q});
  assign k_wrap = k_nxt >= {1'b0, out_c_q};
  assign n_wrap = n_nxt >= {1'b0, num_pix_q};

  assign issuing    = (state_q == S_ISSUE);
  assign desc_valid = issuing;
  assign busy       = issuing;
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign n_base     = n_base_q;
  assign n_len      = n_len_w;
  assign k_base     = k_base_q;
  assign k_len      = k_len_w;
  // Depthwise layers have no d loop: the input slice follows the output slice.
  assign d_base     = dw_q ? k_base_q : d_base_q;
  assign d_len      = dw_q ? k_len_w : d_len_w;
  assign first_d    = issuing && (dw_q || (d_base_q == '0));
  assign last_d     = issuing && (dw_q || (({1'b0, d_base_q} + {1'b0, d_len_w}) == {1'b0, in_c_q}));

  // Latch the layer geometry on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      dw_q      <= 1'b0;
      in_c_q    <= '0;
      out_c_q   <= '0;
      tile_d_q  <= '0;
      tile_k_q  <= '0;
      n_step_q  <= '0;
      num_pix_q <= '0;
    end else if (accept) begin
      dw_q      <= (layer_type == LT_DW);
      in_c_q    <= in_C;
      out_c_q   <= out_C;
      tile_d_q  <= tile_D;
      tile_k_q  <= tile_K;
      n_step_q  <= n_step_new;
      num_pix_q <= num_pix;
    end
  end

  // State, loop counters and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      d_base_q <= '0;
      k_base_q <= '0;
      n_base_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_base_q <= d_base_d;
      k_base_q <= k_base_d;
      n_base_q <= n_base_d;
      err_q    <= err_d;
    end
  end

  // Next state: d innermost, then k, then n; the last handshake ends the walk.
  always_comb begin
    state_d  = state_q;
    d_base_d = d_base_q;
    k_base_d = k_base_q;
    n_base_d = n_base_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d    = cfg_bad;
          d_base_d = '0;
          k_base_d = '0;
          n_base_d = '0;
          state_d  = cfg_bad ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (desc_ready) begin
          if (!d_wrap) begin
            d_base_d = d_nxt[CH_W-1:0];
          end else begin
            d_base_d = '0;
            if (!k_wrap) begin
              k_base_d = k_nxt[CH_W-1:0];
            end else begin
              k_base_d = '0;
              if (!n_wrap) begin
                n_base_d = n_nxt[PIX_W-1:0];
              end else begin
                n_base_d = '0;
                state_d  = S_DONE;
              end
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tile_sched.sv
module tb_tile_sched;
  localparam int PIX_W = 16;
  localparam int CH_W  = 7;

  logic             clk = 1'b0;
  logic             rst, start, desc_ready;
  logic [1:0]       layer_type;
  logic [CH_W-1:0]  in_C, out_C, tile_D, tile_K;
  logic [31:0]      tile_n;
  logic [PIX_W-1:0] num_pix;
  logic             desc_valid, first_d, last_d, busy, done, err;
  logic [CH_W-1:0]  d_base, d_len, k_base, k_len;
  logic [PIX_W-1:0] n_base, n_len;

  always #5 clk = ~clk;

  tile_sched #(.PIX_W(PIX_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_type(layer_type),
    .in_C(in_C), .out_C(out_C), .tile_D(tile_D), .tile_K(tile_K),
    .tile_n(tile_n), .num_pix(num_pix),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .d_base(d_base), .d_len(d_len), .k_base(k_base), .k_len(k_len),
    .n_base(n_base), .n_len(n_len), .first_d(first_d), .last_d(last_d),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct { int db, dl, kb, kl, nb, nl, fd, ld; } desc_t;
  typedef struct { int lt, inc, outc, td, tk; bit [31:0] tn; int np; } cfg_t;

  // Reference model: expected descriptor list plus a coarse run phase
  // (0 idle, 1 streaming, 2 done cycle).
  desc_t q[$];
  int    phase, m_err, hs_run, exp_cnt;
  int    n_tests, n_fail;
  bit    bp;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Expected descriptor stream straight from the loop-nest rules.
  task automatic build(input cfg_t c);
    int ns, nl, kl, dl;
    desc_t e;
    q.delete();
    ns = (longint'(c.tn) < longint'(c.np)) ? int'(c.tn) : c.np;
    for (int n = 0; n < c.np; n += ns) begin
      nl = imin(ns, c.np - n);
      for (int k = 0; k < c.outc; k += c.tk) begin
        kl = imin(c.tk, c.outc - k);
        if (c.lt == 1) begin
          e = '{k, kl, k, kl, n, nl, 1, 1};
          q.push_back(e);
        end else begin
          for (int d = 0; d < c.inc; d += c.td) begin
            dl = imin(c.td, c.inc - d);
            e = '{d, dl, k, kl, n, nl, int'(d == 0), int'(d + dl == c.inc)};
            q.push_back(e);
          end
        end
      end
    end
    exp_cnt = ((c.np + ns - 1) / ns) * ((c.outc + c.tk - 1) / c.tk) *
              ((c.lt == 1) ? 1 : (c.inc + c.td - 1) / c.td);
  endtask

  // One cycle: compare at negedge, advance the model, then step past the posedge.
  task automatic tick();
    desc_t e;
    cfg_t  c;
    bit    bad;
    @(negedge clk);
    chk("desc_valid", desc_valid, phase == 1);
    chk("busy", busy, phase == 1);
    chk("done", done, phase == 2);
    chk("err", err, m_err);
    if (phase == 1 && q.size() > 0) begin
      e = q[0];
      chk("d_base", d_base, e.db);
      chk("d_len", d_len, e.dl);
      chk("k_base", k_base, e.kb);
      chk("k_len", k_len, e.kl);
      chk("n_base", n_base, e.nb);
      chk("n_len", n_len, e.nl);
      chk("first_d", first_d, e.fd);
      chk("last_d", last_d, e.ld);
    end
    if (rst) begin
      phase = 0;
      m_err = 0;
      q.delete();
    end else begin
      case (phase)
        0: if (start) begin
          c.lt = int'(layer_type); c.inc = int'(in_C); c.outc = int'(out_C);
          c.td = int'(tile_D); c.tk = int'(tile_K); c.tn = tile_n; c.np = int'(num_pix);
          bad = (c.tn == 0) || (c.td == 0) || (c.tk == 0) || (c.inc == 0) ||
                (c.outc == 0) || (c.np == 0);
          m_err  = int'(bad);
          hs_run = 0;
          if (bad) begin
            q.delete();
            exp_cnt = 0;
            phase   = 2;
          end else begin
            build(c);
            phase = 1;
          end
        end
        1: if (desc_ready) begin
          void'(q.pop_front());
          hs_run++;
          if (q.size() == 0) phase = 2;
        end
        default: begin
          chk("desc_count", hs_run, exp_cnt);
          phase = 0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    desc_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic apply(input cfg_t c);
    layer_type = 2'(c.lt);
    in_C       = CH_W'(c.inc);
    out_C      = CH_W'(c.outc);
    tile_D     = CH_W'(c.td);
    tile_K     = CH_W'(c.tk);
    tile_n     = c.tn;
    num_pix    = PIX_W'(c.np);
  endtask

  task automatic launch(input cfg_t c);
    apply(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drain the current run; inputs are scrambled while streaming to show they are ignored.
  task automatic run_out(input bit busy_starts, output int cyc);
    cyc = 0;
    for (int i = 0; i < 20000 && phase != 0; i++) begin
      start = busy_starts && (phase == 1) && ($urandom_range(0, 3) == 0);
      if (phase == 1) begin
        layer_type = 2'($urandom);
        in_C       = CH_W'($urandom);
        out_C      = CH_W'($urandom);
        tile_D     = CH_W'($urandom);
        tile_K     = CH_W'($urandom);
        tile_n     = $urandom;
        num_pix    = PIX_W'($urandom);
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("run_timeout_phase", phase, 0);
  endtask

  cfg_t c1, c2, c3, ce, cr, cb;
  int   cyc;
  int   dw_nl[6] = '{10, 10, 10, 10, 5, 5};
  int   dw_kl[6] = '{16, 14, 16, 14, 16, 14};

  initial begin
    n_tests = 0; n_fail = 0; phase = 0; m_err = 0; hs_run = 0; exp_cnt = 0; bp = 1'b0;
    rst = 1'b1; start = 1'b0; desc_ready = 1'b1;
    c1 = '{0, 64, 64, 32, 32, 32'd100, 256};
    c2 = '{2, 40, 20, 16, 8, 32'd1000, 49};
    c3 = '{1, 30, 30, 16, 16, 32'd10, 25};
    apply(c1);
    tick(); tick();
    rst = 1'b0;
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_first_d", first_d, 0);
    chk("rst_last_d", last_d, 0);
    chk("rst_d_base", d_base, 0);
    chk("rst_d_len", d_len, 0);
    chk("rst_k_len", k_len, 0);
    chk("rst_n_len", n_len, 0);

    // Pointwise, full-rate
    launch(c1);
    chk("c1_count", q.size(), 12);
    chk("c1_nlen0", q[0].nl, 100);
    chk("c1_nlen4", q[4].nl, 100);
    chk("c1_nlen8", q[8].nl, 56);
    chk("c1_nbase8", q[8].nb, 200);
    chk("c1_fd0", q[0].fd, 1);
    chk("c1_ld0", q[0].ld, 0);
    chk("c1_db1", q[1].db, 32);
    chk("c1_ld1", q[1].ld, 1);
    run_out(1'b0, cyc);
    chk("c1_cycles_to_done", cyc, 13);

    // Standard conv with ragged d and k
    launch(c2);
    chk("c2_count", q.size(), 9);
    chk("c2_dl0", q[0].dl, 16);
    chk("c2_dl1", q[1].dl, 16);
    chk("c2_dl2", q[2].dl, 8);
    chk("c2_kl3", q[3].kl, 8);
    chk("c2_kl6", q[6].kl, 4);
    chk("c2_nl", q[8].nl, 49);
    run_out(1'b0, cyc);

    // Depthwise
    launch(c3);
    chk("c3_count", q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("c3_nlen", q[i].nl, dw_nl[i]);
      chk("c3_klen", q[i].kl, dw_kl[i]);
    end
    chk("c3_kb1", q[1].kb, 16);
    run_out(1'b0, cyc);

    // Backpressure plus ignored start pulses
    bp = 1'b1;
    launch(c1);
    run_out(1'b1, cyc);
    bp = 1'b0;

    // Config errors, each followed by a clean run
    ce = c2; ce.tn = 32'd0;
    launch(ce);
    run_out(1'b0, cyc);
    chk("err_sticky_tn", err, 1);
    launch(c2);
    run_out(1'b0, cyc);
    ce = c2; ce.inc = 0;
    launch(ce);
    run_out(1'b0, cyc);
    chk("err_sticky_inc", err, 1);
    ce = c3; ce.tk = 0;
    launch(ce);
    run_out(1'b0, cyc);
    launch(c3);
    run_out(1'b0, cyc);

    // Reset in the middle of a run
    launch(c1);
    for (int i = 0; i < 100 && hs_run < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", desc_valid, 0);
    chk("midrst_busy", busy, 0);
    tick(); tick();
    launch(c1);
    chk("restart_n_base", n_base, 0);
    chk("restart_k_base", k_base, 0);
    chk("restart_d_base", d_base, 0);
    run_out(1'b0, cyc);

    // Wide tile_n whose low bits are small, and counter overflow at the extremes
    cb = '{0, 8, 4, 8, 4, 32'h0001_0005, 10};
    launch(cb);
    chk("wide_tn_nlen", q[0].nl, 10);
    run_out(1'b0, cyc);
    cb = '{0, 127, 127, 100, 120, 32'd40000, 65535};
    launch(cb);
    chk("ovf_count", q.size(), 8);
    run_out(1'b0, cyc);

    // Randomized geometry with random backpressure
    for (int r = 0; r < 12; r++) begin
      cr.lt   = int'($urandom_range(0, 3));
      cr.inc  = int'($urandom_range(1, 127));
      cr.outc = int'($urandom_range(1, 127));
      cr.td   = int'($urandom_range(16, 127));
      cr.tk   = int'($urandom_range(16, 127));
      cr.np   = int'($urandom_range(1, 400));
      case ($urandom_range(0, 2))
        0:       cr.tn = $urandom_range(20, 500);
        1:       cr.tn = $urandom | 32'h8000_0000;
        default: cr.tn = 32'h0001_0000 + $urandom_range(1, 50);
      endcase
      bp = 1'($urandom_range(0, 1));
      launch(cr);
      run_out(1'b1, cyc);
    end
    bp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
